mult_arbiter_64: RTL and testbench
==================================

# mult_arbiter_64

Round-robin controller that shares one combinational 64x64 unsigned multiplier (multiplier_64) among NUM_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the registered operands into the shared multiplier. It captures the 128-bit product and returns it to the winning requester over a per-requester response handshake. It sits between the requester clients and the multiplier instance at the level above both.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- WIDTH, 64: operand width; product is 2*WIDTH
- ID_W, $clog2(NUM_REQ): requester index width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_a  in  NUM_REQ*WIDTH  operand A; requester i in slice [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a
- resp_valid  out  NUM_REQ  one-hot result-available flag
- resp_ready  in  NUM_REQ  requester accepts result
- resp_product  out  2*WIDTH  result, shared by all requesters
- resp_id  out  ID_W  index of the requester owning resp_product
- mul_a, mul_b  out  WIDTH  operands to the shared multiplier
- mul_product  in  2*WIDTH  combinational product from the multiplier
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE
  - The arbiter grants the first requester with req_valid set, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready[grant] is high combinationally in the same cycle.
  - On that edge the block latches req_a/req_b slices into the operand registers, latches grant into the owner ID, sets last_grant to the grant, and moves to MUL.
  - If no req_valid bit is set, req_ready is all-zero and the FSM stays in IDLE.
- MUL
  - mul_a/mul_b are driven from the operand registers.
  - On the next edge, mul_product is captured into resp_product, the owner ID goes to resp_id, and the FSM moves to RESP.
- RESP
  - resp_valid[owner] is held high, along with a stable resp_product and resp_id, until resp_ready[owner] is high at an edge.
  - After that edge the FSM returns to IDLE.
  - resp_ready bits of non-owners are ignored.
- Width rules
  - Unsigned only. The product is full 2*WIDTH with no truncation.
  - The block does not compute; all arithmetic is in the multiplier.
- Requester rules
  - req_valid and operands must be held until req_ready.
  - req_valid must not depend on req_ready.
  - A requester may keep req_valid high across operations.
- Boundary conditions
  - All requesters valid: grants rotate 0,1,2,3,0...
  - A single requester continuously valid: it wins every operation.
  - resp_ready held low indefinitely: RESP holds and no new request is accepted.
  - The owner raising req_valid again while in RESP is not accepted until IDLE.
- Reset, including mid-operation
  - State goes to IDLE and last_grant to NUM_REQ-1, so requester 0 has first priority.
  - All operand, product and ID registers clear to 0.
  - Any in-flight operation is discarded with no response.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_product 0, resp_id 0, mul_a 0, mul_b 0, busy 0.
- Cycle sequence:
  - Accept in cycle N.
  - MUL in cycle N+1.
  - resp_valid high from cycle N+2.
  - Earliest return to IDLE is N+3.
  - Next accept is no earlier than N+3, so minimum 3 cycles per operation.
- req_ready is combinational from req_valid and state.
- All other outputs are registered.
- mul_product must settle within one clock period.

## Structure
- Package mult_arb_pkg holds:
  - the state enum: IDLE=2'd0, MUL=2'd1, RESP=2'd2
  - default NUM_REQ and WIDTH constants
- One sub-module: rr_arbiter (parameter NUM_REQ).
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant and encoded grant index.
  - Purely combinational.
- The multiplier_64 instance lives outside this block and connects through mul_a/mul_b/mul_product.

## Test plan
- Requester 0 sends A=5, B=3 with resp_ready high:
  - req_ready[0] in cycle 0.
  - resp_valid[0] in cycle 2 with resp_product=15 and resp_id=0.
  - busy low in cycle 3.
- Requester 2 sends A=B=0xFFFFFFFFFFFFFFFF:
  - resp_product=0xFFFFFFFFFFFFFFFE0000000000000001 and resp_id=2.
- All four requesters valid continuously, with A=i+1 and B=10:
  - Grant order 0,1,2,3,0.
  - Products 10, 20, 30, 40, 10.
  - One accept every 3 cycles.
- Requester 1 sends A=1923842001, B=1409280110; resp_ready[1] held low for 5 cycles:
  - resp_valid[1] and resp_product=2711232266791900110 stay stable throughout.
  - No req_ready while requester 3 is valid.
  - Requester 3 is accepted in the cycle after the response handshake.
- rst asserted in MUL after accepting A=43610, B=1:
  - All outputs 0 immediately.
  - No resp_valid.
  - After release, requester 0 wins first when requesters 0 and 3 are both valid.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the round-robin multiplier arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 64;

endpackage

// File: rtl/mult_arbiter_64_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // Offsets 1..NUM_REQ so last_grant itself is visited last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter_64.sv
// Shares one external combinational multiplier among NUM_REQ requesters,
// one operation at a time: accept -> MUL -> RESP (held until the owner takes it).
module mult_arbiter_64
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     busy
);

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic [ID_W-1:0]      owner_q, owner_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [ID_W-1:0]      resp_id_q, resp_id_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;

    logic [NUM_REQ-1:0]   grant_oh;
    logic [ID_W-1:0]      grant_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        prod_d       = prod_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                req_ready = grant_oh;
                if (|req_valid) begin
                    op_a_d       = req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    op_b_d       = req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = MUL;
                end
            end
            MUL: begin
                prod_d                = mul_product;
                resp_id_d             = owner_q;
                resp_valid_d          = '0;
                resp_valid_d[owner_q] = 1'b1;
                state_d               = RESP;
            end
            RESP: begin
                // Only the owner's ready completes the transfer.
                if (resp_ready[resp_id_q]) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            owner_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            prod_q       <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            prod_q       <= prod_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign mul_a        = op_a_q;
    assign mul_b        = op_b_q;
    assign resp_product = prod_q;
    assign resp_id      = resp_id_q;
    assign resp_valid   = resp_valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter_64.sv
// Directed plus randomized checks of mult_arbiter_64 against a transaction-level model.
module tb_mult_arbiter_64;

    localparam int N = 4;
    localparam int W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic [2*W-1:0]   resp_product, mul_product;
    logic [1:0]       resp_id;
    logic [W-1:0]     mul_a, mul_b;
    logic             busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Stand-in for the external multiplier_64.
    assign mul_product = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    mult_arbiter_64 #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .resp_id      (resp_id),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_product  (mul_product),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // Model: m_age counts cycles since accept (0 = idle, 1 = multiplying, 2 = result pending).
    int             m_age, m_owner, m_last, m_id;
    logic [W-1:0]   m_a, m_b;
    logic [2*W-1:0] m_prod;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age <= 0; m_owner <= 0; m_last <= N - 1; m_id <= 0;
            m_a <= '0; m_b <= '0; m_prod <= '0;
        end else if (m_age == 0) begin
            if (pick(req_valid, m_last) >= 0) begin
                m_owner <= pick(req_valid, m_last);
                m_last  <= pick(req_valid, m_last);
                m_a     <= req_a[pick(req_valid, m_last)*W +: W];
                m_b     <= req_b[pick(req_valid, m_last)*W +: W];
                m_age   <= 1;
            end
        end else if (m_age == 1) begin
            m_prod <= {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
            m_id   <= m_owner;
            m_age  <= 2;
        end else if (resp_ready[m_id]) begin
            m_age <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req_ready", req_ready, (m_age == 0) ? onehot(pick(req_valid, m_last)) : {N{1'b0}});
            chk("m_resp_valid", resp_valid, (m_age == 2) ? onehot(m_id) : {N{1'b0}});
            chk("m_resp_product", resp_product, m_prod);
            chk("m_resp_id", resp_id, m_id);
            chk("m_mul_a", mul_a, m_a);
            chk("m_mul_b", mul_b, m_b);
            chk("m_busy", busy, m_age != 0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [N-1:0]   gq[$];
    int             gc[$];
    logic [2*W-1:0] pq[$];
    logic [N-1:0]   acc;

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
        chk_en = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_product", resp_product, 0);
        chk("rst_busy", busy, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Requester 0: 5 * 3
        req_valid = 4'b0001; req_a[0 +: W] = 64'd5; req_b[0 +: W] = 64'd3; resp_ready = '1;
        @(negedge clk); chk("t1_ready_c0", req_ready, 4'b0001);
        next_cycle(); req_valid = '0;
        @(negedge clk); chk("t1_busy_c1", busy, 1);
        next_cycle();
        @(negedge clk);
        chk("t1_resp_valid_c2", resp_valid, 4'b0001);
        chk("t1_product", resp_product, 128'd15);
        chk("t1_id", resp_id, 0);
        next_cycle();
        @(negedge clk); chk("t1_busy_c3", busy, 0);

        // Requester 2: all-ones squared
        next_cycle();
        req_valid = 4'b0100; req_a[2*W +: W] = '1; req_b[2*W +: W] = '1;
        @(negedge clk); chk("t2_ready", req_ready, 4'b0100);
        next_cycle(); req_valid = '0;
        next_cycle();
        @(negedge clk);
        chk("t2_product", resp_product, 128'hFFFFFFFFFFFFFFFE0000000000000001);
        chk("t2_id", resp_id, 2);
        next_cycle();

        // Fresh reset, then all four requesters continuously valid
        rst = 1'b1; next_cycle(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 64'(i + 1);
            req_b[i*W +: W] = 64'd10;
        end
        req_valid = '1; resp_ready = '1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin gq.push_back(req_ready); gc.push_back(c); end
            if (resp_valid != 0) pq.push_back(resp_product);
            next_cycle();
        end
        chk("t3_num_grants", gq.size(), 5);
        chk("t3_num_resps", pq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) begin
                chk("t3_grant_order", gq[k], onehot(k % N));
                chk("t3_grant_cycle", gc[k], 3 * k);
            end
            if (k < pq.size()) chk("t3_product", pq[k], 128'(10 * (k % N + 1)));
        end

        // Requester 1 with resp_ready withheld; requester 3 waiting
        req_valid = 4'b0010;
        req_a[1*W +: W] = 64'd1923842001; req_b[1*W +: W] = 64'd1409280110;
        resp_ready = 4'b1101;
        @(negedge clk); chk("t4_ready", req_ready, 4'b0010);
        next_cycle();
        req_valid = 4'b1000; req_a[3*W +: W] = 64'd7; req_b[3*W +: W] = 64'd9;
        @(negedge clk); chk("t4_ready_mul", req_ready, 0);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_hold_valid", resp_valid, 4'b0010);
            chk("t4_hold_product", resp_product, 128'd2711232266791900110);
            chk("t4_hold_ready", req_ready, 0);
            next_cycle();
        end
        resp_ready = '1;
        @(negedge clk); chk("t4_still_valid", resp_valid, 4'b0010);
        next_cycle();
        @(negedge clk); chk("t4_req3_accept", req_ready, 4'b1000);
        next_cycle(); req_valid = '0;
        next_cycle(); next_cycle();

        // Reset during MUL
        req_valid = 4'b0001; req_a[0 +: W] = 64'd43610; req_b[0 +: W] = 64'd1;
        @(negedge clk); chk("t5_ready", req_ready, 4'b0001);
        next_cycle(); req_valid = '0;
        @(negedge clk); chk("t5_mul_a", mul_a, 128'd43610);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_mul_a", mul_a, 0);
        chk("t5_rst_mul_b", mul_b, 0);
        chk("t5_rst_resp_valid", resp_valid, 0);
        chk("t5_rst_product", resp_product, 0);
        chk("t5_rst_id", resp_id, 0);
        next_cycle(); rst = 1'b0;
        @(negedge clk); chk("t5_no_resp", resp_valid, 0);
        next_cycle();
        req_valid = 4'b1001; req_a[3*W +: W] = 64'd2; req_b[3*W +: W] = 64'd2;
        @(negedge clk); chk("t5_prio0", req_ready, 4'b0001);
        next_cycle(); req_valid = 4'b1000;
        next_cycle(); next_cycle();
        @(negedge clk); chk("t5_then3", req_ready, 4'b1000);
        next_cycle(); req_valid = '0;
        next_cycle(); next_cycle();

        // Randomized traffic obeying the requester rules
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i*W +: W] = rnd_op();
                    req_b[i*W +: W] = rnd_op();
                end
            end
            resp_ready = N'($urandom);
            @(negedge clk);
            acc = req_ready;
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                    else begin
                        req_a[i*W +: W] = rnd_op();
                        req_b[i*W +: W] = rnd_op();
                    end
                end
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
